// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like master port between instruction fetch and data.
// Data has fixed priority; a starvation counter forces an inst grant after STARVE_LIMIT data wins.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StAddr, StResp} state_t;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic       r_grant;      // 0 = inst, 1 = data
  logic [3:0] r_starve_cnt;

  logic w_inst_forced;
  logic w_in_addr;
  logic w_in_resp;
  logic w_addr_ok;
  logic w_data_ok;

  assign w_inst_forced = inst_req && (r_starve_cnt == Limit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_grant      <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (data_req && !w_inst_forced) begin
            r_grant      <= 1'b1;
            r_state      <= StAddr;
            // Counter only ever reaches Limit, where inst wins, so it saturates there.
            r_starve_cnt <= inst_req ? r_starve_cnt + 4'd1 : 4'd0;
          end else if (inst_req) begin
            r_grant      <= 1'b0;
            r_state      <= StAddr;
            r_starve_cnt <= 4'd0;
          end
        end
        StAddr: begin
          if (m_addr_ok) begin
            r_state <= m_data_ok ? StIdle : StResp;
          end
        end
        StResp: begin
          if (m_data_ok) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_in_addr = (r_state == StAddr);
  assign w_in_resp = (r_state == StResp);
  assign w_addr_ok = w_in_addr && m_addr_ok;
  // Coincident addr_ok/data_ok in ADDR completes the transaction in one cycle.
  assign w_data_ok = (w_in_resp && m_data_ok) || (w_addr_ok && m_data_ok);

  always_comb begin
    m_req   = w_in_addr;
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (w_in_addr) begin
      m_wr    = r_grant ? data_wr    : inst_wr;
      m_size  = r_grant ? data_size  : inst_size;
      m_addr  = r_grant ? data_addr  : inst_addr;
      m_wdata = r_grant ? data_wdata : inst_wdata;
    end
  end

  assign inst_addr_ok = w_addr_ok && !r_grant;
  assign data_addr_ok = w_addr_ok &&  r_grant;
  assign inst_data_ok = w_data_ok && !r_grant;
  assign data_data_ok = w_data_ok &&  r_grant;

  assign inst_rdata = (r_state != StIdle) ? m_rdata : 32'd0;
  assign data_rdata = (r_state != StIdle) ? m_rdata : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: stimulus pushes expected handshakes into queues,
// a negedge monitor pops and compares whenever the arbiter asserts addr_ok or data_ok.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } addr_exp_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
  } resp_exp_t;

  addr_exp_t q_addr[$];
  resp_exp_t q_resp[$];

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    addr_exp_t ea;
    resp_exp_t er;
    if (rst) begin
      if (inst_addr_ok || data_addr_ok) begin
        if (q_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected addr_ok: got inst=%0b data=%0b want none",
                   inst_addr_ok, data_addr_ok);
        end else begin
          ea = q_addr.pop_front();
          check("addr_ok both ports", 32'(inst_addr_ok & data_addr_ok), 32'd0);
          check("addr_ok port", 32'(data_addr_ok), 32'(ea.port));
          check("m_req at addr_ok", 32'(m_req), 32'd1);
          check("m_addr", m_addr, ea.addr);
          check("m_wr", 32'(m_wr), 32'(ea.wr));
          check("m_size", 32'(m_size), 32'(ea.size));
          check("m_wdata", m_wdata, ea.wdata);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (q_resp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected data_ok: got inst=%0b data=%0b want none",
                   inst_data_ok, data_data_ok);
        end else begin
          er = q_resp.pop_front();
          check("data_ok both ports", 32'(inst_data_ok & data_data_ok), 32'd0);
          check("data_ok port", 32'(data_data_ok), 32'(er.port));
          check("rdata", data_data_ok ? data_rdata : inst_rdata, er.rdata);
        end
      end
    end
  end

  // Called with the arbiter in IDLE and the requester's fields already driven.
  task automatic xfer(input bit port, input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic [31:0] wd, input logic [31:0] rd, input int addr_wait,
                      input int resp_wait, input bit coincide, input bit drop);
    check("m_req low in idle", 32'(m_req), 32'd0);
    step();
    check("m_req one cycle after request", 32'(m_req), 32'd1);
    repeat (addr_wait) step();
    q_addr.push_back('{port, a, w, s, wd});
    m_addr_ok = 1'b1;
    if (coincide) begin
      q_resp.push_back('{port, rd});
      m_data_ok = 1'b1;
      m_rdata   = rd;
    end
    step();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    m_rdata   = 32'h0;
    if (drop) begin
      if (port) data_req = 1'b0;
      else      inst_req = 1'b0;
    end
    check("m_req low after addr_ok", 32'(m_req), 32'd0);
    if (!coincide) begin
      repeat (resp_wait) step();
      q_resp.push_back('{port, rd});
      m_data_ok = 1'b1;
      m_rdata   = rd;
      step();
      m_data_ok = 1'b0;
      m_rdata   = 32'h0;
    end
  endtask

  initial begin
    rst = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b00; inst_addr = '0; inst_wdata = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = '0; data_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Reset state, with the bridge driving handshakes that must be ignored
    #12;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
    data_req = 1'b1;
    #1;
    check("reset m_req", 32'(m_req), 32'd0);
    check("reset data_addr_ok", 32'(data_addr_ok), 32'd0);
    check("reset data_data_ok", 32'(data_data_ok), 32'd0);
    check("reset inst_rdata", inst_rdata, 32'd0);
    check("reset m_addr", m_addr, 32'd0);
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single data read
    data_req = 1'b1; data_addr = 32'h1FC0_0010; data_size = 2'b10;
    xfer(1'b1, 32'h1FC0_0010, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, 1'b1);

    // Simultaneous requests: data first, then inst
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_size = 2'b10;
    data_req = 1'b1; data_addr = 32'h1000_0040; data_size = 2'b10;
    xfer(1'b1, 32'h1000_0040, 1'b0, 2'b10, 32'h0, 32'h1111_1111, 0, 0, 1'b0, 1'b1);
    check("starve_cnt after one data win", 32'(dut.r_starve_cnt), 32'd1);
    xfer(1'b0, 32'hBFC0_0000, 1'b0, 2'b10, 32'h0, 32'h2222_2222, 1, 0, 1'b0, 1'b1);
    check("starve_cnt after inst grant", 32'(dut.r_starve_cnt), 32'd0);

    // Starvation: data x4, inst x1, data again
    inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
    data_req = 1'b1; data_addr = 32'h1000_0080;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 32'h1000_0080, 1'b0, 2'b10, 32'h0, 32'h3000_0000 + 32'(i), 0, 0, 1'b0, 1'b0);
    end
    check("starve_cnt at limit", 32'(dut.r_starve_cnt), 32'd4);
    xfer(1'b0, 32'hBFC0_0040, 1'b0, 2'b10, 32'h0, 32'h4444_0000, 0, 0, 1'b0, 1'b1);
    check("starve_cnt cleared by inst", 32'(dut.r_starve_cnt), 32'd0);
    xfer(1'b1, 32'h1000_0080, 1'b0, 2'b10, 32'h0, 32'h5555_0000, 0, 0, 1'b0, 1'b1);
    check("starve_cnt data without inst", 32'(dut.r_starve_cnt), 32'd0);

    // Coincident handshakes on the inst port, then stray handshakes must be ignored
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; inst_size = 2'b10;
    xfer(1'b0, 32'hBFC0_0100, 1'b0, 2'b10, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b1);
    m_data_ok = 1'b1; m_addr_ok = 1'b1; m_rdata = 32'h0BAD_0BAD;
    #1;
    check("stray inst_data_ok after coincide", 32'(inst_data_ok), 32'd0);
    check("stray m_req after coincide", 32'(m_req), 32'd0);
    step();
    m_data_ok = 1'b0; m_addr_ok = 1'b0; m_rdata = 32'h0;

    // Byte write routing
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00;
    data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
    xfer(1'b1, 32'h8000_0003, 1'b1, 2'b00, 32'h0000_00AB, 32'h0, 0, 2, 1'b0, 1'b1);
    data_wr = 1'b0; data_wdata = 32'h0;

    // Reset while waiting for data_ok
    data_req = 1'b1; data_addr = 32'h1000_0100; data_size = 2'b10;
    step();
    q_addr.push_back('{1'b1, 32'h1000_0100, 1'b0, 2'b10, 32'h0});
    m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0; data_req = 1'b0;
    m_rdata = 32'h7777_7777;
    #1;
    check("rdata passthrough in resp", data_rdata, 32'h7777_7777);
    #1;
    rst = 1'b0;
    #1;
    check("reset clears rdata at once", data_rdata, 32'd0);
    check("reset m_req", 32'(m_req), 32'd0);
    check("reset data_data_ok", 32'(data_data_ok), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    step();
    m_data_ok = 1'b1; m_rdata = 32'h8888_8888;
    #1;
    check("late data_ok masked", 32'(data_data_ok), 32'd0);
    check("late data_ok inst masked", 32'(inst_data_ok), 32'd0);
    step();
    m_data_ok = 1'b0; m_rdata = 32'h0;
    step();

    check("addr queue drained", 32'(q_addr.size()), 32'd0);
    check("resp queue drained", 32'(q_resp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
